accumulate_host: RTL
====================

# accumulate_host

Host-side sequencer that sits directly upstream of the `main` accumulate kernel. It accepts a job command, then streams `DEPTH` 64-bit words from a valid/ready input into the kernel's array through the kernel's `controlArr*` port. It then starts the kernel with the latched `init_i`/`init_acc`, waits for the kernel's `w_enable`, and presents the returned result bit with a one-cycle `done` pulse.

## Interface
Parameters:
- `DEPTH`, default 1000: words loaded per job; kernel array size.
- `AW`, default 10: address width, `$clog2(DEPTH)`.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: job start request; sampled in IDLE only.
- `cmd_i` in AW: kernel `init_i` for this job.
- `cmd_acc` in 64, signed: kernel `init_acc` for this job.
- `s_valid` in 1: load-stream word valid.
- `s_ready` out 1: load-stream ready.
- `s_data` in 64, signed: load-stream word.
- `busy` out 1: job in progress; high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `result_o` out 1: kernel result, held until the next `done`.
- `k_r_enable` out 1: drives kernel `r_enable`.
- `k_init_i` out AW: drives kernel `init_i`.
- `k_init_acc` out 64: drives kernel `init_acc`.
- `k_controlArr` out 1: drives kernel `controlArr`.
- `k_we` out 1: drives kernel `controlArrWEnable_a`.
- `k_addr` out AW: drives kernel `controlArrAddr_a`.
- `k_wdata` out 64: drives kernel `controlArrWData_a`.
- `k_w_enable` in 1: kernel done flag.
- `k_result` in 1: kernel result.

## Operation
State machine: IDLE → LOAD → START → RUN → IDLE.

- **IDLE**
  - `k_r_enable`=1, which parks the kernel at state 0 and clears its `w_enable`.
  - On `cmd_valid`, latch `cmd_i` and `cmd_acc` into `k_init_i` and `k_init_acc`, clear the address counter, and go to LOAD.
- **LOAD**
  - `k_controlArr`=1, `k_r_enable`=1, `s_ready`=1.
  - On an `s_valid & s_ready` handshake, `k_we`=1, `k_addr`=cnt and `k_wdata`=`s_data`. All three are combinational from the handshake, so the kernel memory writes at the same edge.
  - Outside a handshake, `k_we`=0 and `k_wdata`=0. `k_addr` stays equal to cnt.
  - cnt increments per handshake. The handshake with cnt==DEPTH-1 moves to START; cnt never reaches DEPTH.
- **START**
  - One cycle: `k_controlArr`=0, `k_r_enable`=1, `s_ready`=0.
  - This guarantees the kernel samples the latched init values with arbitration released.
- **RUN**
  - `k_r_enable`=0 and the kernel executes.
  - When `k_w_enable`=1: `result_o` ← `k_result`, `done` pulses for one cycle, go to IDLE.
- `cmd_valid` outside IDLE is ignored. No queueing, no error flag.
- `k_init_i` and `k_init_acc` hold their latched values until the next accepted command.
- `s_data` arriving while `s_ready`=0 is not consumed.

Reset (asynchronous, any state, including mid-LOAD or mid-RUN):
- state=IDLE, cnt=0, `busy`=0, `done`=0, `result_o`=0, `s_ready`=0.
- `k_controlArr`=0, `k_we`=0, `k_addr`=0, `k_wdata`=0, `k_r_enable`=1, `k_init_i`=0, `k_init_acc`=0.
- Words already written to the kernel array stay in memory. A new job overwrites all DEPTH entries.

## Timing
- `cmd_valid` at edge N: LOAD from N+1; `s_ready` is high in cycle N+1.
- Load duration: exactly DEPTH handshakes, at most one per cycle. With `s_valid` held high, LOAD lasts DEPTH cycles.
- START is exactly 1 cycle. `k_r_enable` first drops in the cycle after START.
- `k_w_enable` sampled high at edge M: `done`=1 and `result_o` updated in cycle M+1. `busy` falls in the same cycle.
- A new `cmd_valid` is accepted from the cycle `done` is high, since that cycle is already IDLE.
- Minimum job length: 1 + DEPTH + 1 + kernel latency + 1 cycles.
- `s_ready`, `busy` and `done` are registered-state decodes with no combinational path from `s_valid`. The `k_we`, `k_addr` and `k_wdata` write path is combinational from `s_valid`.

## Test plan
The kernel is replaced by a stub that asserts `w_enable` with `result`=1 exactly 20 cycles after `r_enable` falls, and holds it until `r_enable` rises. A second bench binds the real `main`.

- **Full load:** cmd(i=0, acc=5), stream `s_data`=k for k=0..999 back-to-back.
  - Array holds mem[k]=k.
  - `s_ready` is high for exactly 1000 cycles.
  - START is 1 cycle; `done` follows 21 cycles after START; `result_o`=1.
- **Backpressure:** `s_valid` toggling 1,0,1,0.
  - Exactly 1000 writes at addresses 0..999 in order, no duplicates.
  - LOAD lasts 1999 cycles.
- **Ignored command:** `cmd_valid` pulse mid-LOAD with i=7.
  - `k_init_i` keeps the first job's value.
  - Only one `done` is produced.
- **Reset mid-LOAD:** assert `rst` after 500 words.
  - All outputs take reset values immediately.
  - A new job then loads 1000 words, starting from address 0.
- **Back-to-back jobs:** assert `cmd_valid` during the `done` cycle.
  - The second job enters LOAD on the next cycle.
  - The second job's data overwrites all entries.
- **Boundary:** the 1000th word is accepted with `k_addr`=999. `s_ready`=0 in the following cycle. An extra `s_valid` word is not written.

Source files
------------

// File: rtl/accumulate_host.sv
// accumulate_host: host-side sequencer for the accumulate kernel.
// A job is handled in four steps. First it latches the init values from a
// command. It then streams DEPTH words into the kernel array, releases
// arbitration for one START cycle, and runs the kernel. When the kernel
// finishes, the result is reported with a one-cycle done pulse.
module accumulate_host #(
    parameter int DEPTH = 1000,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    // job command
    input  logic                 cmd_valid,
    input  logic [AW-1:0]        cmd_i,
    input  logic signed [63:0]   cmd_acc,
    // load stream
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [63:0]   s_data,
    // status / result
    output logic                 busy,
    output logic                 done,
    output logic                 result_o,
    // kernel control
    output logic                 k_r_enable,
    output logic [AW-1:0]        k_init_i,
    output logic signed [63:0]   k_init_acc,
    output logic                 k_controlArr,
    output logic                 k_we,
    output logic [AW-1:0]        k_addr,
    output logic signed [63:0]   k_wdata,
    input  logic                 k_w_enable,
    input  logic                 k_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Address of the final word of a load; reaching it ends the load phase.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t                state_reg;
    logic [AW-1:0]         cnt_reg;
    logic [AW-1:0]         init_i_reg;
    logic signed [63:0]    init_acc_reg;
    logic                  result_reg;
    logic                  done_reg;
    logic                  load_hs;

    // A word is consumed only while loading; s_ready is a pure state decode.
    assign load_hs = s_valid && (state_reg == LOAD);

    // Job sequencing, address counter, latched init values and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            init_i_reg   <= '0;
            init_acc_reg <= '0;
            result_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        init_i_reg   <= cmd_i;
                        init_acc_reg <= cmd_acc;
                        cnt_reg      <= '0;
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        if (cnt_reg == LAST_ADDR) begin
                            // Park the counter at 0 so k_addr idles at 0.
                            cnt_reg   <= '0;
                            state_reg <= START;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                START: begin
                    // One cycle with arbitration released so the kernel
                    // samples the latched init values before it runs.
                    state_reg <= RUN;
                end
                RUN: begin
                    if (k_w_enable) begin
                        result_reg <= k_result;
                        done_reg   <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Status outputs decode from registered state only.
    assign s_ready  = (state_reg == LOAD);
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign result_o = result_reg;

    // Kernel control: r_enable parks the kernel in every state except RUN.
    assign k_r_enable   = (state_reg != RUN);
    assign k_controlArr = (state_reg == LOAD);
    assign k_init_i     = init_i_reg;
    assign k_init_acc   = init_acc_reg;

    // Array write path is combinational from the handshake, so the kernel
    // memory captures the word on the same edge that consumes it.
    assign k_we    = load_hs;
    assign k_addr  = cnt_reg;
    assign k_wdata = load_hs ? s_data : 64'sd0;

endmodule
